// File: rtl/gauss_cfg_pkg.sv
// Shared constants for the configurable 3x3 Gaussian stage.
//   DEF_COEF  : coefficient set loaded at reset (raster order, index 4 = centre)
//   PIPE_LAT  : input pixel to ovalid latency in cycles
//   sum_width : width of the full 9-tap accumulation
package gauss_cfg_pkg;

    localparam int PIPE_LAT = 5;
    localparam int NUM_TAPS = 9;

    localparam int unsigned DEF_COEF [NUM_TAPS] = '{27, 29, 27, 29, 32, 29, 27, 29, 27};

    // Products are dw+gw bits; summing nine of them needs 4 more bits.
    function automatic int sum_width(input int dw, input int gw);
        return dw + gw + 4;
    endfunction

endpackage

// File: rtl/gauss_filter_cfg_if.sv
// Pixel stream and configuration bus for gauss_filter_cfg.
//   master : pixel source / register writer (drives isync..bypass_i)
//   slave  : the filter (drives osync, ovalid, odata_g, odata_y)
interface gauss_filter_cfg_if #(
    parameter int DATAWIDTH   = 8,
    parameter int G_DATAWIDTH = 10,
    parameter int SHIFT_W     = 4
);
    logic                   isync;
    logic                   ivalid;
    logic [DATAWIDTH-1:0]   idata;
    logic                   coef_we;
    logic [3:0]             coef_addr;
    logic [G_DATAWIDTH-1:0] coef_wdata;
    logic                   shift_we;
    logic [SHIFT_W-1:0]     shift_wdata;
    logic                   bypass_i;
    logic                   osync;
    logic                   ovalid;
    logic [DATAWIDTH-1:0]   odata_g;
    logic [DATAWIDTH-1:0]   odata_y;

    modport master (
        output isync, ivalid, idata, coef_we, coef_addr, coef_wdata,
               shift_we, shift_wdata, bypass_i,
        input  osync, ovalid, odata_g, odata_y
    );

    modport slave (
        input  isync, ivalid, idata, coef_we, coef_addr, coef_wdata,
               shift_we, shift_wdata, bypass_i,
        output osync, ovalid, odata_g, odata_y
    );
endinterface

// File: rtl/gauss_window_3x3.sv
// 3x3 sliding window generator: two line buffers, row/col counters and a
// 3x3 register array, all advanced only on ivalid.
//   iclk, rst_i       : clock, async active-low reset
//   isync             : frame start; the coincident pixel is row 0 / col 0
//   ivalid, idata     : input pixel stream
//   win_valid         : window registers hold a complete 3x3 neighbourhood
//   win_pix           : 9 pixels, raster order, index 0 = top-left (LSBs)
//   win_centre        : window centre pixel (same as win_pix index 4)
module gauss_window_3x3 #(
    parameter int PERIOD_X  = 864,
    parameter int DATAWIDTH = 8
) (
    input  logic                   iclk,
    input  logic                   rst_i,
    input  logic                   isync,
    input  logic                   ivalid,
    input  logic [DATAWIDTH-1:0]   idata,
    output logic                   win_valid,
    output logic [9*DATAWIDTH-1:0] win_pix,
    output logic [DATAWIDTH-1:0]   win_centre
);
    localparam int COL_W = (PERIOD_X > 1) ? $clog2(PERIOD_X) : 1;

    logic [COL_W-1:0]     col, cur_col;
    logic [1:0]           row, cur_row;
    logic                 framed;
    logic [DATAWIDTH-1:0] lb0 [PERIOD_X];   // previous line
    logic [DATAWIDTH-1:0] lb1 [PERIOD_X];   // line before that
    logic [DATAWIDTH-1:0] tap1, tap2;
    logic [DATAWIDTH-1:0] win [9];

    // Position of the pixel presented this cycle; isync restarts the raster.
    assign cur_col = isync ? '0 : col;
    assign cur_row = isync ? '0 : row;
    assign tap1    = lb0[cur_col];
    assign tap2    = lb1[cur_col];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge iclk or negedge rst_i) begin
        if (!rst_i) begin
            col    <= '0;
            row    <= '0;
            framed <= 1'b0;
        end else begin
            if (isync)
                framed <= 1'b1;
            if (ivalid) begin
                if (cur_col == COL_W'(PERIOD_X - 1)) begin
                    col <= '0;
                    row <= (cur_row == 2'd3) ? 2'd3 : cur_row + 2'd1;
                end else begin
                    col <= cur_col + COL_W'(1);
                    row <= cur_row;
                end
            end else if (isync) begin
                col <= '0;
                row <= '0;
            end
        end
    end

    // NOTE: line-buffer RAM has no reset; stale contents are never used
    // because a window only qualifies once two fresh lines have been written.
    always_ff @(posedge iclk) begin
        if (ivalid) begin
            lb0[cur_col] <= idata;
            lb1[cur_col] <= lb0[cur_col];
        end
    end

    // Until the first isync after reset the raster position is unknown, so
    // no window may qualify.
    always_ff @(posedge iclk or negedge rst_i) begin
        if (!rst_i) begin
            win_valid <= 1'b0;
            for (int i = 0; i < 9; i++)
                win[i] <= '0;
        end else begin
            win_valid <= ivalid && framed && (cur_row >= 2'd2) && (cur_col >= COL_W'(2));
            if (ivalid) begin
                for (int r = 0; r < 3; r++) begin
                    win[r*3]   <= win[r*3+1];
                    win[r*3+1] <= win[r*3+2];
                end
                win[2] <= tap2;
                win[5] <= tap1;
                win[8] <= idata;
            end
        end
    end

    for (genvar i = 0; i < 9; i++) begin : g_pack
        assign win_pix[i*DATAWIDTH +: DATAWIDTH] = win[i];
    end
    assign win_centre = win[4];

endmodule

// File: rtl/gauss_filter_cfg.sv
// Configurable 3x3 Gaussian filter with frame-synchronous coefficient,
// normalisation-shift and bypass commit.
//   iclk, rst_i : clock, async active-low reset
//   bus         : pixel stream in, coefficient/shift writes, bypass request,
//                 filtered pixel (odata_g) and aligned centre (odata_y) out
// Latency: 5 cycles from input pixel to ovalid; osync is isync delayed 5.
module gauss_filter_cfg
    import gauss_cfg_pkg::*;
#(
    parameter int PERIOD_X    = 864,
    parameter int DATAWIDTH   = 8,
    parameter int G_DATAWIDTH = 10,
    parameter int SHIFT_W     = 4,
    parameter int RST_SHIFT   = 8
) (
    input  logic                iclk,
    input  logic                rst_i,
    gauss_filter_cfg_if.slave   bus
);
    localparam int PW   = DATAWIDTH + G_DATAWIDTH;
    localparam int RSW  = PW + 2;
    localparam int SUMW = sum_width(DATAWIDTH, G_DATAWIDTH);
    localparam int RW   = SUMW + 1;
    localparam logic [RW-1:0] MAX_PIX = RW'((2 ** DATAWIDTH) - 1);

    logic                   win_valid;
    logic [9*DATAWIDTH-1:0] win_pix;
    logic [DATAWIDTH-1:0]   win_centre;

    gauss_window_3x3 #(.PERIOD_X(PERIOD_X), .DATAWIDTH(DATAWIDTH)) u_window (
        .iclk(iclk), .rst_i(rst_i), .isync(bus.isync), .ivalid(bus.ivalid),
        .idata(bus.idata), .win_valid(win_valid), .win_pix(win_pix),
        .win_centre(win_centre)
    );

    // Shadow set is written freely; active set only changes at isync, so a
    // write coinciding with isync reaches the active set one frame later.
    logic [G_DATAWIDTH-1:0] shd_coef [NUM_TAPS];
    logic [G_DATAWIDTH-1:0] act_coef [NUM_TAPS];
    logic [SHIFT_W-1:0]     shd_shift, act_shift;
    logic                   act_bypass;

    always_ff @(posedge iclk or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                shd_coef[i] <= G_DATAWIDTH'(DEF_COEF[i]);
                act_coef[i] <= G_DATAWIDTH'(DEF_COEF[i]);
            end
            shd_shift  <= SHIFT_W'(RST_SHIFT);
            act_shift  <= SHIFT_W'(RST_SHIFT);
            act_bypass <= 1'b0;
        end else begin
            if (bus.coef_we && (bus.coef_addr < 4'd9))
                shd_coef[bus.coef_addr] <= bus.coef_wdata;
            if (bus.shift_we)
                shd_shift <= bus.shift_wdata;
            if (bus.isync) begin
                act_coef   <= shd_coef;
                act_shift  <= shd_shift;
                act_bypass <= bus.bypass_i;
            end
        end
    end

    // Shift and bypass travel with the data so a commit at isync cannot
    // alter pixels of the previous frame still in flight.
    logic [PW-1:0]        prod [NUM_TAPS];
    logic [RSW-1:0]       rsum [3];
    logic [SUMW-1:0]      total;
    logic                 v1, v2, v3, by1, by2, by3;
    logic [DATAWIDTH-1:0] c1, c2, c3;
    logic [SHIFT_W-1:0]   sh1, sh2, sh3;
    logic [PIPE_LAT-1:0]  sync_dly;
    logic                 ovalid_q;
    logic [DATAWIDTH-1:0] odata_g_q, odata_y_q, norm;
    logic [RW-1:0]        rnd, shifted;

    always_ff @(posedge iclk or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < NUM_TAPS; i++)
                prod[i] <= '0;
            for (int r = 0; r < 3; r++)
                rsum[r] <= '0;
            total     <= '0;
            {v1, v2, v3, by1, by2, by3} <= '0;
            {c1, c2, c3}    <= '0;
            {sh1, sh2, sh3} <= '0;
            sync_dly  <= '0;
            ovalid_q  <= 1'b0;
            odata_g_q <= '0;
            odata_y_q <= '0;
        end else begin
            // S1: products
            for (int i = 0; i < NUM_TAPS; i++)
                prod[i] <= PW'(win_pix[i*DATAWIDTH +: DATAWIDTH]) * PW'(act_coef[i]);
            v1 <= win_valid;  c1 <= win_centre;  sh1 <= act_shift;  by1 <= act_bypass;
            // S2: row sums
            for (int r = 0; r < 3; r++)
                rsum[r] <= RSW'(prod[3*r]) + RSW'(prod[3*r+1]) + RSW'(prod[3*r+2]);
            v2 <= v1;  c2 <= c1;  sh2 <= sh1;  by2 <= by1;
            // S3: total
            total <= SUMW'(rsum[0]) + SUMW'(rsum[1]) + SUMW'(rsum[2]);
            v3 <= v2;  c3 <= c2;  sh3 <= sh2;  by3 <= by2;
            // S4: normalised output
            ovalid_q <= v3;
            if (v3) begin
                odata_g_q <= by3 ? c3 : norm;
                odata_y_q <= c3;
            end
            sync_dly <= {sync_dly[PIPE_LAT-2:0], bus.isync};
        end
    end

    // Round half-up, shift, saturate.
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        rnd = RW'(total);
        if (sh3 != '0)
            rnd = rnd + (RW'(1) << (sh3 - SHIFT_W'(1)));
        shifted = rnd >> sh3;
        norm    = (shifted > MAX_PIX) ? {DATAWIDTH{1'b1}} : shifted[DATAWIDTH-1:0];
    end

    assign bus.osync   = sync_dly[PIPE_LAT-1];
    assign bus.ovalid  = ovalid_q;
    assign bus.odata_g = odata_g_q;
    assign bus.odata_y = odata_y_q;

endmodule

// File: tb/tb_gauss_filter_cfg.sv
// Scoreboard bench for gauss_filter_cfg (PERIOD_X=8). The driver keeps an
// image array plus shadow/active settings and pushes the expected output of
// every complete window; a negedge monitor pops and compares on ovalid.
module tb_gauss_filter_cfg;
    localparam int P = 8, DW = 8, GW = 10, SW = 4, MAXH = 8;

    logic iclk  = 1'b0;
    logic rst_i = 1'b1;
    always #5 iclk = ~iclk;

    gauss_filter_cfg_if #(.DATAWIDTH(DW), .G_DATAWIDTH(GW), .SHIFT_W(SW)) bus ();

    gauss_filter_cfg #(
        .PERIOD_X(P), .DATAWIDTH(DW), .G_DATAWIDTH(GW), .SHIFT_W(SW), .RST_SHIFT(8)
    ) dut (
        .iclk(iclk), .rst_i(rst_i), .bus(bus)
    );

    typedef struct { int g; int y; } exp_t;
    typedef struct { bit is_shift; int addr; int val; } wr_t;

    exp_t exp_q [$];
    int   sync_q [$];
    wr_t  wr_q [$];
    exp_t mon_e;

    int checks = 0, failures = 0;
    int cyc = 0, out_cnt = 0, first_cyc = -1, pix22_cyc = -1;
    int img [MAXH][P];
    int def_coef [9] = '{27, 29, 27, 29, 32, 29, 27, 29, 27};
    int shd_coef [9], act_coef [9];
    int shd_shift, act_shift;
    bit act_byp;
    int wr_start = 0, gap_pct = 0;
    bit rnd_wr = 1'b0, toggle_byp = 1'b0;

    always @(posedge iclk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: weighted 3x3 sum, half-up rounding, shift, clamp to 255.
    function automatic exp_t model_out(input int r, input int c);
        exp_t e;
        int   acc = 0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                acc += img[r-2+dr][c-2+dc] * act_coef[dr*3+dc];
        if (act_shift > 0) acc += 1 << (act_shift - 1);
        acc = acc >> act_shift;
        e.y = img[r-1][c-1];
        e.g = act_byp ? e.y : ((acc > 255) ? 255 : acc);
        return e;
    endfunction

    task automatic model_reset();
        shd_coef = def_coef;  act_coef = def_coef;
        shd_shift = 8;  act_shift = 8;  act_byp = 1'b0;
        exp_q.delete();  sync_q.delete();  wr_q.delete();
    endtask

    task automatic clk1();
        @(posedge iclk);
        #1;
    endtask

    task automatic fill(input int mode, input int v);
        for (int r = 0; r < MAXH; r++)
            for (int c = 0; c < P; c++)
                img[r][c] = (mode == 0) ? int'($urandom_range(0, 255)) :
                            (mode == 1) ? v : ((r * 37 + c * 11) % 256);
    endtask

    // Drives at most one register write this cycle and mirrors it in the shadow model.
    task automatic apply_writes(input int pix_idx);
        wr_t w;
        bus.coef_we  = 1'b0;
        bus.shift_we = 1'b0;
        if (wr_q.size() != 0 && pix_idx >= wr_start) begin
            w = wr_q.pop_front();
        end else if (rnd_wr && $urandom_range(0, 5) == 0) begin
            w.is_shift = ($urandom_range(0, 3) == 0);
            w.addr     = int'($urandom_range(0, 15));
            w.val      = w.is_shift ? int'($urandom_range(2, 10)) : int'($urandom_range(0, 63));
        end else begin
            return;
        end
        if (w.is_shift) begin
            bus.shift_we = 1'b1;  bus.shift_wdata = SW'(w.val);  shd_shift = w.val;
        end else begin
            bus.coef_we = 1'b1;  bus.coef_addr = 4'(w.addr);  bus.coef_wdata = GW'(w.val);
            if (w.addr < 9) shd_coef[w.addr] = w.val;
        end
    endtask

    task automatic send_frame(input int h, input bit byp, input bit sync_px, input int abort_at);
        int idx = 0;
        bus.isync = 1'b1;
        bus.bypass_i = byp;
        act_coef = shd_coef;  act_shift = shd_shift;  act_byp = byp;
        sync_q.push_back(cyc);
        first_cyc = -1;
        if (!sync_px) begin
            apply_writes(0);
            clk1();
            bus.isync = 1'b0;  bus.coef_we = 1'b0;  bus.shift_we = 1'b0;
        end
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < P; c++) begin
                while (gap_pct > 0 && !bus.isync && $urandom_range(0, 99) < gap_pct) begin
                    bus.ivalid = 1'b0;
                    apply_writes(idx);
                    if (toggle_byp) bus.bypass_i = 1'($urandom_range(0, 1));
                    clk1();
                end
                bus.ivalid = 1'b1;
                bus.idata  = DW'(img[r][c]);
                if (r >= 2 && c >= 2) begin
                    exp_q.push_back(model_out(r, c));
                    if (r == 2 && c == 2) pix22_cyc = cyc;
                end
                apply_writes(idx);
                if (toggle_byp && !bus.isync) bus.bypass_i = 1'($urandom_range(0, 1));
                clk1();
                bus.isync = 1'b0;  bus.ivalid = 1'b0;
                bus.coef_we = 1'b0;  bus.shift_we = 1'b0;
                if (idx == abort_at) return;
                idx++;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || sync_q.size() != 0) && n < 50) begin
            clk1();
            n++;
        end
        check("drain_pending", exp_q.size() + sync_q.size(), 0);
        exp_q.delete();  sync_q.delete();
        repeat (3) clk1();
    endtask

    always @(negedge iclk) begin
        if (rst_i) begin
            if (bus.ovalid) begin
                out_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_ovalid", int'(bus.ovalid), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("odata_g", int'(bus.odata_g), mon_e.g);
                    check("odata_y", int'(bus.odata_y), mon_e.y);
                end
            end
            if (bus.osync) begin
                if (sync_q.size() == 0) check("unexpected_osync", int'(bus.osync), 0);
                else check("osync_latency", cyc - sync_q.pop_front(), 5);
            end
        end
    end

    initial begin
        bus.isync = 1'b0;  bus.ivalid = 1'b0;  bus.idata = '0;
        bus.coef_we = 1'b0;  bus.coef_addr = '0;  bus.coef_wdata = '0;
        bus.shift_we = 1'b0;  bus.shift_wdata = '0;  bus.bypass_i = 1'b0;
        model_reset();
        #1 rst_i = 1'b0;
        #10;
        check("rst_ovalid",  int'(bus.ovalid),  0);
        check("rst_osync",   int'(bus.osync),   0);
        check("rst_odata_g", int'(bus.odata_g), 0);
        check("rst_odata_y", int'(bus.odata_y), 0);
        clk1();
        rst_i = 1'b1;
        clk1();

        // Flat 100 with reset defaults: count and first-output latency.
        fill(1, 100);
        out_cnt = 0;
        send_frame(6, 1'b0, 1'b0, -1);
        drain();
        check("flat_count", out_cnt, 24);
        check("first_latency", first_cyc - pix22_cyc, 5);

        // Impulse at (3,3) with ivalid gaps.
        fill(1, 0);
        img[3][3] = 255;
        gap_pct = 30;
        send_frame(6, 1'b0, 1'b0, -1);
        drain();

        // Saturating set written mid-frame: current frame keeps defaults.
        for (int i = 0; i < 9; i++) wr_q.push_back('{1'b0, i, 1023});
        wr_q.push_back('{1'b1, 0, 0});
        wr_start = 10;
        gap_pct  = 20;
        fill(1, 255);
        send_frame(6, 1'b0, 1'b0, -1);
        // Next frame saturates; meanwhile load coef=1, shift=3, ignored addr 12.
        for (int i = 0; i < 9; i++) wr_q.push_back('{1'b0, i, 1});
        wr_q.push_back('{1'b1, 0, 3});
        wr_q.push_back('{1'b0, 12, 500});
        send_frame(6, 1'b0, 1'b1, -1);
        // Flat 200 -> 225; a write in the isync cycle only reaches the shadow set.
        wr_start = 0;
        wr_q.push_back('{1'b0, 4, 9});
        fill(1, 200);
        send_frame(6, 1'b0, 1'b0, -1);
        drain();

        // Bypass latched at isync; bypass_i toggling mid-frame is ignored.
        toggle_byp = 1'b1;
        fill(2, 0);
        send_frame(6, 1'b1, 1'b0, -1);
        send_frame(6, 1'b0, 1'b0, -1);
        drain();

        // Random back-to-back frames with random writes, gaps and sync placement.
        rnd_wr = 1'b1;
        for (int f = 0; f < 6; f++) begin
            fill(0, 0);
            send_frame(int'($urandom_range(3, 7)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), -1);
        end
        drain();
        rnd_wr = 1'b0;  toggle_byp = 1'b0;  gap_pct = 0;  bus.bypass_i = 1'b0;

        // Reset mid-line while ovalid is high.
        fill(0, 0);
        send_frame(6, 1'b0, 1'b0, 3 * P + 7);
        check("pre_rst_ovalid", int'(bus.ovalid), 1);
        rst_i = 1'b0;
        #1;
        check("midrst_ovalid",  int'(bus.ovalid),  0);
        check("midrst_odata_g", int'(bus.odata_g), 0);
        model_reset();
        clk1();
        rst_i = 1'b1;
        // Lines without isync must not produce output.
        out_cnt = 0;
        for (int i = 0; i < 3 * P; i++) begin
            bus.ivalid = 1'b1;
            bus.idata  = DW'($urandom_range(0, 255));
            clk1();
        end
        bus.ivalid = 1'b0;
        drain();
        check("no_out_before_sync", out_cnt, 0);
        fill(0, 0);
        out_cnt = 0;
        send_frame(6, 1'b0, 1'b0, -1);
        drain();
        check("post_rst_count", out_cnt, 24);
        check("post_rst_latency", first_cyc - pix22_cyc, 5);

        // Reset while osync is high.
        bus.isync = 1'b1;
        sync_q.push_back(cyc);
        clk1();
        bus.isync = 1'b0;
        repeat (4) clk1();
        check("pre_rst_osync", int'(bus.osync), 1);
        rst_i = 1'b0;
        #1;
        check("midrst_osync", int'(bus.osync), 0);
        model_reset();
        clk1();
        rst_i = 1'b1;
        clk1();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
